// File: rtl/err_sampler.sv
// ADC front end for the PI loop: offset-binary -> signed, block average,
// and error against a slew-limited (soft-start) reference.
module err_sampler #(
  parameter int N_ADC      = 14,
  parameter int ADC_OFFSET = 8192,
  parameter int LOG2_AVG   = 4,
  parameter int REF_STEP   = 100
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_enable,
  input  logic [N_ADC-1:0]    i_ADC,
  input  logic                i_ADC_valid,
  input  logic signed [31:0]  i_ref,
  output logic signed [31:0]  o_meas,
  output logic signed [31:0]  o_ref_ramp,
  output logic signed [31:0]  o_err,
  output logic                o_valid,
  output logic [1:0]          o_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, TRACK = 2'd2} state_t;

  localparam logic signed [32:0] STEP33 = 33'(REF_STEP);

  state_t               state_q, state_d;
  logic signed [31:0]   acc_q, acc_d;
  logic [LOG2_AVG-1:0]  cnt_q, cnt_d;
  logic signed [31:0]   meas_q, meas_d;
  logic signed [31:0]   ramp_q, ramp_d;
  logic signed [31:0]   err_q, err_d;
  logic                 valid_q, valid_d;

  logic signed [31:0]   samp, sum, avg, ramp_nxt;
  logic signed [32:0]   ramp_up, ramp_dn, ref33;
  logic                 last;

  assign samp = $signed({{(32-N_ADC){1'b0}}, i_ADC}) - $signed(32'(ADC_OFFSET));
  assign sum  = acc_q + samp;
  assign avg  = sum >>> LOG2_AVG;
  assign last = &cnt_q;

  // Slew step done in 33 bits so ramp +/- REF_STEP cannot wrap near the rails.
  assign ramp_up = $signed({ramp_q[31], ramp_q}) + STEP33;
  assign ramp_dn = $signed({ramp_q[31], ramp_q}) - STEP33;
  assign ref33   = $signed({i_ref[31], i_ref});

  always_comb begin
    ramp_nxt = ramp_q;
    if (ramp_q < i_ref)
      ramp_nxt = (ramp_up > ref33) ? i_ref : ramp_up[31:0];
    else if (ramp_q > i_ref)
      ramp_nxt = (ramp_dn < ref33) ? i_ref : ramp_dn[31:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    meas_d  = meas_q;
    ramp_d  = ramp_q;
    err_d   = err_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d  = '0;
        cnt_d  = '0;
        ramp_d = '0;
        err_d  = '0;
        if (i_enable) state_d = RAMP;
      end
      RAMP, TRACK: begin
        if (!i_enable) begin
          // Enable beats a coincident sample; partial block is dropped.
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ramp_d  = '0;
          err_d   = '0;
        end else if (i_ADC_valid) begin
          if (!last) begin
            acc_d = sum;
            cnt_d = cnt_q + LOG2_AVG'(1);
          end else begin
            meas_d  = avg;
            err_d   = ramp_q - avg;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            ramp_d  = ramp_nxt;
            state_d = (ramp_nxt == i_ref) ? TRACK : RAMP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      meas_q  <= '0;
      ramp_q  <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      meas_q  <= meas_d;
      ramp_q  <= ramp_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign o_meas     = meas_q;
  assign o_ref_ramp = ramp_q;
  assign o_err      = err_q;
  assign o_valid    = valid_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_err_sampler.sv
// Bench for err_sampler: table of 16-sample blocks with hand-derived results,
// scoreboarded against each o_valid pulse, plus enable/reset corner sequences.
module tb_err_sampler;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic [13:0]        adc = '0;
  logic               adc_valid = 1'b0;
  logic signed [31:0] ref_in = '0;
  logic signed [31:0] meas, ramp, err;
  logic               valid;
  logic [1:0]         state;

  err_sampler dut (
    .i_CLK(clk), .i_RST(rst_n), .i_enable(enable), .i_ADC(adc),
    .i_ADC_valid(adc_valid), .i_ref(ref_in), .o_meas(meas),
    .o_ref_ramp(ramp), .o_err(err), .o_valid(valid), .o_state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a0, a1;
    int ref_early, ref_last, gap;
    int meas, err, ramp, st;
  } blk_t;

  typedef struct {
    int meas, err, ramp, st, due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   vcount = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every o_valid must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        vcount++;
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("valid_latency", cyc, e.due);
          chk("meas", meas, e.meas);
          chk("err", err, e.err);
          chk("ramp", ramp, e.ramp);
          chk("state", state, e.st);
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        chk("missing_valid", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  task automatic push(input int m, input int e, input int r, input int s);
    exp_t x;
    x = '{m, e, r, s, cyc + 1};
    q.push_back(x);
  endtask

  task automatic sample(input logic [13:0] a, input int gap);
    adc = a;
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic run_block(input blk_t b);
    for (int i = 0; i < 16; i++) begin
      ref_in = (i == 15) ? b.ref_last : b.ref_early;
      if (i == 15) push(b.meas, b.err, b.ramp, b.st);
      sample((i % 2 == 0) ? b.a0 : b.a1, b.gap);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  blk_t tbl[12];

  initial begin
    int v0;
    // Soft start from 0 toward 500, s=+100 each sample, one valid per 4 clocks.
    tbl[0]  = '{14'd8292, 14'd8292, 500, 500, 3, 100, -100, 100, 1};
    tbl[1]  = '{14'd8292, 14'd8292, 500, 500, 3, 100,    0, 200, 1};
    tbl[2]  = '{14'd8292, 14'd8292, 500, 500, 3, 100,  100, 300, 1};
    tbl[3]  = '{14'd8292, 14'd8292, 500, 500, 3, 100,  200, 400, 1};
    tbl[4]  = '{14'd8292, 14'd8292, 500, 500, 3, 100,  300, 500, 2};
    tbl[5]  = '{14'd8292, 14'd8292, 500, 500, 3, 100,  400, 500, 2};
    // s=-1,-2 alternating: sum -24, arithmetic shift gives -2.
    tbl[6]  = '{14'd8191, 14'd8190, 500, 500, 1,  -2,  502, 500, 2};
    // Ramp down to 250, last step clipped.
    tbl[7]  = '{14'd8292, 14'd8292, 250, 250, 1, 100,  400, 400, 1};
    tbl[8]  = '{14'd8292, 14'd8292, 250, 250, 1, 100,  300, 300, 1};
    tbl[9]  = '{14'd8292, 14'd8292, 250, 250, 1, 100,  200, 250, 2};
    // Reference wanders mid-block; only the value at completion counts.
    tbl[10] = '{14'd8292, 14'd8292, 10000, 260, 1, 100, 150, 260, 2};
    tbl[11] = '{14'd8292, 14'd8292, -5000, 260, 1, 100, 160, 260, 2};

    // Reset state
    idle_cycles(3);
    chk("rst_meas", meas, 0);
    chk("rst_err", err, 0);
    chk("rst_ramp", ramp, 0);
    chk("rst_valid", valid, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;
    idle_cycles(1);
    chk("idle_hold_state", state, 0);
    enable = 1'b1;
    idle_cycles(1);
    chk("enable_state", state, 1);

    for (int i = 0; i < 12; i++) run_block(tbl[i]);
    idle_cycles(2);

    // Counter wrap: 48 back-to-back samples -> exactly 3 pulses.
    v0 = vcount;
    ref_in = 260;
    for (int i = 0; i < 48; i++) begin
      if (i % 16 == 15) push(100, 160, 260, 2);
      sample(14'd8292, 0);
    end
    idle_cycles(3);
    chk("wrap_pulses", vcount - v0, 3);

    // Enable drop coincident with what would be the completing sample.
    for (int i = 0; i < 15; i++) sample(14'd8292, 1);
    enable = 1'b0;
    sample(14'd8292, 0);
    chk("drop_state", state, 0);
    chk("drop_ramp", ramp, 0);
    chk("drop_err", err, 0);
    chk("drop_valid", valid, 0);
    chk("drop_meas_hold", meas, 100);
    for (int i = 0; i < 3; i++) sample(14'd8292, 1);
    chk("idle_ignore_state", state, 0);
    enable = 1'b1;
    idle_cycles(1);
    chk("reenable_state", state, 1);
    run_block('{14'd8292, 14'd8292, 260, 260, 1, 100, -100, 100, 1});
    idle_cycles(2);

    // Async reset between edges, mid-block.
    for (int i = 0; i < 5; i++) sample(14'd8292, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_meas", meas, 0);
    chk("arst_err", err, 0);
    chk("arst_ramp", ramp, 0);
    chk("arst_valid", valid, 0);
    chk("arst_state", state, 0);
    #1 rst_n = 1'b1;
    idle_cycles(1);
    chk("arst_restart_state", state, 1);
    run_block('{14'd8292, 14'd8292, 260, 260, 1, 100, -100, 100, 1});

    for (int i = 0; i < 20 && q.size() != 0; i++) idle_cycles(1);
    chk("sb_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
